// File: rtl/ysyx_25030093_pkg.sv
// Shared types and constants for the ysyx_25030093 core.
package ysyx_25030093_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: one outstanding read per committed pc, result held for the IDU.
// Optional macro YSYX_25030093_IFU_ALIGN_CHECK_EN faults misaligned pcs without a bus access.
//
// state | meaning
// IDLE  | waiting for a committed pc (or the boot fetch after reset)
// REQ   | arvalid high, read address presented
// RESP  | rready high, waiting for read data
// HOLD  | out_valid high, instruction held until IDU accepts
module ysyx_25030093_ifu
  import ysyx_25030093_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        in_valid_WBU,
  output logic        arvalid,
  output logic [31:0] araddr,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault
);

  ifu_state_e state;
  logic       boot;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      boot      <= 1'b1;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      out_valid <= 1'b0;
      fault     <= 1'b0;
      inst      <= NOP_INST;
      inst_pc   <= 32'h0;
      araddr    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          // boot and a coinciding pulse collapse into the same single fetch
          if (boot || in_valid_WBU) begin
            boot    <= 1'b0;
            inst_pc <= pc;
`ifdef YSYX_25030093_IFU_ALIGN_CHECK_EN
            if (pc[1:0] != 2'b00) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              fault     <= 1'b1;
              inst      <= NOP_INST;
            end else begin
              state   <= REQ;
              arvalid <= 1'b1;
              araddr  <= pc;
            end
`else
            state   <= REQ;
            arvalid <= 1'b1;
            araddr  <= pc;
`endif
          end
        end
        REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (rvalid) begin
            rready    <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
            if (rresp != RESP_OKAY) begin
              fault <= 1'b1;
              inst  <= NOP_INST;
            end else begin
              fault <= 1'b0;
              inst  <= rdata;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Directed self-checking bench for ysyx_25030093_ifu.
module tb_ysyx_25030093_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        in_valid_WBU;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;

  int passes = 0;
  int total  = 0;
  int ar_hs  = 0;

  always #5 clk = ~clk;

  ysyx_25030093_ifu #(.NOP_INST(32'h00000013)) dut (
    .clk(clk), .rst(rst), .pc(pc), .in_valid_WBU(in_valid_WBU),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst(inst), .inst_pc(inst_pc), .fault(fault)
  );

  always @(posedge clk) if (rst && arvalid && arready) ar_hs <= ar_hs + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0; pc = 32'h80000000; in_valid_WBU = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; out_ready = 1'b0;
    tick(); tick();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_inst", inst, 32'h00000013);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_araddr", araddr, 0);

    // boot fetch
    rst = 1'b1; arready = 1'b1;
    tick();
    chk("boot_arvalid", arvalid, 1);
    chk("boot_araddr", araddr, 32'h80000000);
    rvalid = 1'b1; rdata = 32'h00000297;
    tick();
    chk("boot_rready", rready, 1);
    chk("boot_arvalid_drop", arvalid, 0);
    tick();
    chk("boot_out_valid", out_valid, 1);
    chk("boot_inst", inst, 32'h00000297);
    chk("boot_inst_pc", inst_pc, 32'h80000000);
    chk("boot_fault", fault, 0);
    rvalid = 1'b0; out_ready = 1'b1;
    tick();
    chk("boot_done", out_valid, 0);
    out_ready = 1'b0;
    tick();
    chk("idle_no_refetch", arvalid, 0);

    // backpressure on both channels
    arready = 1'b0; pc = 32'h80000004; in_valid_WBU = 1'b1;
    tick();
    in_valid_WBU = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_arvalid_held", arvalid, 1);
      chk("bp_araddr_held", araddr, 32'h80000004);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h00400093;
    tick();
    rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_inst_held", inst, 32'h00400093);
      chk("bp_inst_pc_held", inst_pc, 32'h80000004);
      chk("bp_no_new_ar", arvalid, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_done", out_valid, 0);
    out_ready = 1'b0;
    chk("bp_one_fetch", ar_hs, 2);

    // bus error response
    arready = 1'b1; pc = 32'h80000008; in_valid_WBU = 1'b1;
    tick();
    in_valid_WBU = 1'b0;
    tick();
    rvalid = 1'b1; rresp = 2'b10; rdata = 32'hdeadbeef;
    tick();
    chk("err_out_valid", out_valid, 1);
    chk("err_fault", fault, 1);
    chk("err_inst", inst, 32'h00000013);
    chk("err_inst_pc", inst_pc, 32'h80000008);
    rvalid = 1'b0; rresp = 2'b00; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // pulse during RESP is ignored
    pc = 32'h8000000c; in_valid_WBU = 1'b1;
    tick();
    in_valid_WBU = 1'b0;
    tick();
    pc = 32'h80000010; in_valid_WBU = 1'b1;
    tick();
    in_valid_WBU = 1'b0;
    chk("ign_rready", rready, 1);
    chk("ign_arvalid", arvalid, 0);
    chk("ign_araddr", araddr, 32'h8000000c);
    rvalid = 1'b1; rdata = 32'h00000001;
    tick();
    chk("ign_fault_clear", fault, 0);
    chk("ign_inst", inst, 32'h00000001);
    rvalid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("ign_no_queued_fetch", arvalid, 0);
    in_valid_WBU = 1'b1;
    tick();
    in_valid_WBU = 1'b0;
    chk("idle_pulse_arvalid", arvalid, 1);
    chk("idle_pulse_araddr", araddr, 32'h80000010);
    tick();
    rvalid = 1'b1; rdata = 32'h00000002;
    tick();
    rvalid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ign_fetch_count", ar_hs, 5);

    // misaligned pc
    pc = 32'h80000002; in_valid_WBU = 1'b1;
    tick();
    in_valid_WBU = 1'b0;
`ifdef YSYX_25030093_IFU_ALIGN_CHECK_EN
    chk("mis_arvalid", arvalid, 0);
    chk("mis_out_valid", out_valid, 1);
    chk("mis_fault", fault, 1);
    chk("mis_inst", inst, 32'h00000013);
    chk("mis_inst_pc", inst_pc, 32'h80000002);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`else
    chk("mis_arvalid", arvalid, 1);
    chk("mis_araddr", araddr, 32'h80000002);
    tick();
    rvalid = 1'b1; rdata = 32'h00000003;
    tick();
    chk("mis_fault", fault, 0);
    chk("mis_inst_pc", inst_pc, 32'h80000002);
    rvalid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    // reset in the middle of a fetch
    pc = 32'h80000020; in_valid_WBU = 1'b1;
    tick();
    in_valid_WBU = 1'b0;
    tick();
    chk("mid_in_resp", rready, 1);
    rst = 1'b0;
    tick();
    chk("mid_arvalid", arvalid, 0);
    chk("mid_rready", rready, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_inst", inst, 32'h00000013);
    chk("mid_araddr", araddr, 0);
    // release together with a pulse: still exactly one boot fetch
    rst = 1'b1; pc = 32'h80000000; in_valid_WBU = 1'b1;
    tick();
    in_valid_WBU = 1'b0;
    chk("reboot_arvalid", arvalid, 1);
    chk("reboot_araddr", araddr, 32'h80000000);
    tick();
    rvalid = 1'b1; rdata = 32'h00000297;
    tick();
    chk("reboot_out_valid", out_valid, 1);
    chk("reboot_inst", inst, 32'h00000297);
    rvalid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick(); tick();
    chk("reboot_single_fetch", arvalid, 0);
    chk("reboot_out_idle", out_valid, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
